// File: rtl/output_decoding.sv
// Nibble-serial output decoder: accumulates unsigned LUT partial products with
// 4-bit positional weights, restores the sign, and hands the product downstream.
module output_decoding #(
  parameter  int N_NIBBLES = 4,
  localparam int RES_W     = 4*N_NIBBLES+6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_pp,
  input  logic             in_neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_result
);

  localparam int ACC_W = RES_W-1;
  localparam int CNT_W = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_NIBBLES-1);

  typedef enum logic [1:0] {ACC, FIX, OUT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               neg_q, neg_d;
  logic [RES_W-1:0]   out_result_q, out_result_d;
  logic               out_valid_q, out_valid_d;

  assign in_ready   = (state_q == ACC);
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    neg_d        = neg_q;
    out_result_d = out_result_q;
    out_valid_d  = out_valid_q;
    case (state_q)
      ACC: if (in_valid) begin
        // beat 0 loads instead of adding, so no clear cycle between operations
        if (cnt_q == '0) begin
          acc_d = ACC_W'(in_pp);
          neg_d = in_neg;
        end else begin
          acc_d = acc_q + (ACC_W'(in_pp) << {cnt_q, 2'b00});
        end
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FIX: begin
        // two's-complement of zero wraps back to zero in RES_W bits
        out_result_d = neg_q ? (~{1'b0, acc_q} + RES_W'(1)) : {1'b0, acc_q};
        out_valid_d  = 1'b1;
        state_d      = OUT;
      end
      OUT: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d     = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ACC;
      cnt_q        <= '0;
      acc_q        <= '0;
      neg_q        <= 1'b0;
      out_result_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      neg_q        <= neg_d;
      out_result_q <= out_result_d;
      out_valid_q  <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_output_decoding.sv
// Directed bench for output_decoding (N_NIBBLES=4, 22-bit signed result).
module tb_output_decoding;

  localparam int N     = 4;
  localparam int RES_W = 4*N+6;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_pp;
  logic             in_neg;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_result;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int t_a, t_b;

  output_decoding #(.N_NIBBLES(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pp(in_pp), .in_neg(in_neg),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // present one beat for one cycle; called and returns at a negedge
  task automatic send(input logic [7:0] pp, input logic neg);
    in_valid = 1'b1; in_pp = pp; in_neg = neg;
    @(negedge clk);
    in_valid = 1'b0; in_pp = 8'hxx; in_neg = 1'bx;
  endtask

  task automatic wait_result(input string tag);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pp = '0; in_neg = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", 32'(out_result), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // exact latency: FIX cycle, then out_valid
    send(8'h01, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
    chk("lat_fix_valid", 32'(out_valid), 32'd0);
    chk("lat_fix_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    chk("one_result", 32'(out_result), 32'h000001);
    @(negedge clk);
    chk("one_hs_valid", 32'(out_valid), 32'd0);
    chk("one_hs_ready", 32'(in_ready), 32'd1);

    // maximum magnitude, negated
    repeat (4) send(8'hFF, 1'b1);
    wait_result("max");
    chk("max_result", 32'(out_result), 32'h2F0011);
    @(negedge clk);

    // negating zero
    repeat (4) send(8'h00, 1'b1);
    wait_result("zero");
    chk("zero_result", 32'(out_result), 32'h000000);
    @(negedge clk);

    // gaps between beats, then a downstream stall with junk on the input
    send(8'h12, 1'b0); repeat (3) @(negedge clk);
    send(8'h34, 1'b0); repeat (3) @(negedge clk);
    send(8'h56, 1'b0); repeat (3) @(negedge clk);
    out_ready = 1'b0;
    send(8'h78, 1'b0);
    wait_result("gap");
    in_valid = 1'b1; in_pp = 8'hFF; in_neg = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_result", 32'(out_result), 32'h7D952);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_valid", 32'(out_valid), 32'd0);
    chk("result_held", 32'(out_result), 32'h7D952);

    // asynchronous reset mid-operation
    send(8'h05, 1'b0); send(8'h07, 1'b0); send(8'h09, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_result", 32'(out_result), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(8'h02, 1'b1); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
    wait_result("post_rst");
    chk("post_rst_result", 32'(out_result), 32'h3FFFFE);
    @(negedge clk);

    // back-to-back; in_neg on beats 1..3 must be ignored
    send(8'h03, 1'b1); send(8'h00, 1'b0); send(8'h00, 1'b1); send(8'h00, 1'b0);
    @(negedge clk);
    chk("b2b_a_valid", 32'(out_valid), 32'd1);
    chk("b2b_a_result", 32'(out_result), 32'h3FFFFD);
    t_a = cyc;
    @(negedge clk);
    send(8'h04, 1'b0); send(8'h00, 1'b1); send(8'h00, 1'b0); send(8'h00, 1'b1);
    @(negedge clk);
    chk("b2b_b_valid", 32'(out_valid), 32'd1);
    chk("b2b_b_result", 32'(out_result), 32'h000004);
    t_b = cyc;
    chk("b2b_period", 32'(t_b - t_a), 32'd6);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
